fp32_div_seq: RTL and testbench

Multi-cycle fp32 divider computing quotient = a / b using radix-2 restoring mantissa division with round-to-nearest-even. It complements the combinational reciprocal block: that block produces 1/x, and this one consumes a dividend and divisor directly and returns a/b. It sits behind valid/ready handshakes on both sides, so it can be dropped into the FPU pipeline and stall either side. Small area, one operation in flight.

---
 rtl/fp32_pkg.sv | 37 +++
 rtl/fp32_div_step.sv | 18 +
 rtl/fp32_div_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_fp32_div_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared fp32 field widths, constants, FSM state type and operand classification.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0001;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        ROUND,
        DONE
    } state_t;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic is_zero;
    } fp_class_t;

    // Denormals report as zero, so the flush-to-zero happens here.
    function automatic fp_class_t classify(input logic [31:0] x);
        fp_class_t c;
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] f;
        e = x[30:23];
        f = x[22:0];
        c.is_nan  = (e == '1) && (f != '0);
        c.is_inf  = (e == '1) && (f == '0);
        c.is_zero = (e == '0);
        return c;
    endfunction

endpackage

// File: rtl/fp32_div_step.sv
// One restoring division step: compare, conditionally subtract the divisor, shift left.
module fp32_div_step (
    input  logic [24:0] rem_i,
    input  logic [23:0] mb_i,
    output logic [24:0] rem_o,
    output logic        q_bit_o
);

    logic [25:0] diff;
    logic [24:0] rem_sel;

    // The remainder stays below twice the divisor, so the difference never needs bit 25.
    assign diff    = {1'b0, rem_i} - {2'b00, mb_i};
    assign q_bit_o = ~diff[25];
    assign rem_sel = q_bit_o ? diff[24:0] : rem_i;
    assign rem_o   = rem_sel << 1;

endmodule

// File: rtl/fp32_div_seq.sv
// Multi-cycle fp32 divider (restoring, RNE, FTZ) behind valid/ready handshakes.
// Optional out_flags port enabled by defining FP32_DIV_FLAGS_EN.
module fp32_div_seq
    import fp32_pkg::*;
#(
    parameter int          BITS_PER_CYCLE = 1,
    parameter logic [31:0] QNAN           = fp32_pkg::QNAN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef FP32_DIV_FLAGS_EN
    output logic [4:0]  out_flags,
`endif
    output logic [31:0] out_result
);

    localparam int            STEPS      = (27 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int            QW         = STEPS * BITS_PER_CYCLE;
    // Quotient bits beyond the 27 we need only matter as sticky information.
    localparam logic [QW-1:0] EXTRA_MASK = QW'((1 << (QW - 27)) - 1);

    state_t             state_q, state_d;
    logic [24:0]        rem_q, rem_d;
    logic [23:0]        mb_q, mb_d;
    logic [QW-1:0]      q_q, q_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        result_q, result_d;
`ifdef FP32_DIV_FLAGS_EN
    logic [4:0]         flags_q, flags_d;
    logic [4:0]         special_flags, round_flags;
`endif

    // Restoring step chain
    logic [24:0]               rem_chain [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] q_bits;

    assign rem_chain[0] = rem_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        fp32_div_step u_step (
            .rem_i   (rem_chain[i]),
            .mb_i    (mb_q),
            .rem_o   (rem_chain[i+1]),
            .q_bit_o (q_bits[BITS_PER_CYCLE-1-i])
        );
    end

    // Operand classification and special-case results
    fp_class_t   ca, cb;
    logic        sign_in;
    logic        is_special;
    logic [31:0] special_res;

    assign ca         = classify(in_a);
    assign cb         = classify(in_b);
    assign sign_in    = in_a[31] ^ in_b[31];
    assign is_special = ca.is_nan | cb.is_nan | ca.is_inf | cb.is_inf | ca.is_zero | cb.is_zero;

    always_comb begin
        special_res = {sign_in, 31'b0};
`ifdef FP32_DIV_FLAGS_EN
        special_flags = '0;
`endif
        if (ca.is_nan || cb.is_nan || (ca.is_inf && cb.is_inf) || (ca.is_zero && cb.is_zero)) begin
            special_res = QNAN;
`ifdef FP32_DIV_FLAGS_EN
            special_flags[4] = 1'b1;
`endif
        end else if (ca.is_inf || cb.is_zero) begin
            special_res = {sign_in, POS_INF[30:0]};
`ifdef FP32_DIV_FLAGS_EN
            special_flags[3] = cb.is_zero & ~ca.is_inf;
`endif
        end
    end

    // Normalize, round to nearest even, range check
    logic [26:0]       q27;
    logic              sticky_div;
    logic [22:0]       frac;
    logic              guard, sticky, round_up;
    logic [23:0]       frac_inc;
    logic signed [9:0] exp_n, exp_r;
    logic              ovf, unf;
    logic [31:0]       round_res;

    assign q27        = q_q[QW-1 -: 27];
    assign sticky_div = (rem_q != '0) | (|(q_q & EXTRA_MASK));

    always_comb begin
        if (q27[26]) begin
            frac   = q27[25:3];
            guard  = q27[2];
            sticky = sticky_div | (|q27[1:0]);
            exp_n  = exp_q;
        end else begin
            frac   = q27[24:2];
            guard  = q27[1];
            sticky = sticky_div | q27[0];
            exp_n  = exp_q - 10'sd1;
        end
        round_up = guard & (sticky | frac[0]);
        // An all-ones fraction wraps to zero and carries into the exponent.
        frac_inc = {1'b0, frac} + {23'd0, round_up};
        exp_r    = exp_n + $signed({9'd0, frac_inc[23]});
        ovf      = (exp_r >= 10'sd255);
        unf      = (exp_r <= 10'sd0);
        if (ovf) begin
            round_res = {sign_q, POS_INF[30:0]};
        end else if (unf) begin
            round_res = {sign_q, 31'b0};
        end else begin
            round_res = {sign_q, exp_r[7:0], frac_inc[22:0]};
        end
`ifdef FP32_DIV_FLAGS_EN
        round_flags = {1'b0, 1'b0, ovf, unf, guard | sticky | ovf | unf};
`endif
    end

    // Next-state logic
    // NOTE: every signal assigned in this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        mb_d     = mb_q;
        q_d      = q_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef FP32_DIV_FLAGS_EN
        flags_d  = flags_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = sign_in;
                    if (is_special) begin
                        result_d = special_res;
`ifdef FP32_DIV_FLAGS_EN
                        flags_d  = special_flags;
`endif
                        state_d  = DONE;
                    end else begin
                        rem_d   = {2'b01, in_a[22:0]};
                        mb_d    = {1'b1, in_b[22:0]};
                        q_d     = '0;
                        cnt_d   = '0;
                        exp_d   = $signed({2'b00, in_a[30:23]}) - $signed({2'b00, in_b[30:23]})
                                  + 10'sd127;
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                rem_d = rem_chain[BITS_PER_CYCLE];
                q_d   = (q_q << BITS_PER_CYCLE) | QW'(q_bits);
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(STEPS - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                result_d = round_res;
`ifdef FP32_DIV_FLAGS_EN
                flags_d  = round_flags;
`endif
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            mb_q     <= '0;
            q_q      <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef FP32_DIV_FLAGS_EN
            flags_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            mb_q     <= mb_d;
            q_q      <= q_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
`ifdef FP32_DIV_FLAGS_EN
            flags_q  <= flags_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;
`ifdef FP32_DIV_FLAGS_EN
    assign out_flags  = flags_q;
`endif

endmodule

// File: tb/tb_fp32_div_seq.sv
// Self-checking bench for fp32_div_seq: directed cases, backpressure, mid-divide reset,
// and randomized operands against a real-arithmetic reference model.
module tb_fp32_div_seq;

    localparam int BPC        = 1;
    localparam int NORMAL_LAT = (27 + BPC - 1) / BPC + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
`ifdef FP32_DIV_FLAGS_EN
    logic [4:0]  out_flags;
    logic [4:0]  last_flags;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fp32_div_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef FP32_DIV_FLAGS_EN
        .out_flags  (out_flags),
`endif
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact quotient of the significands in double precision (correctly rounded
    // to 53 bits, which is innocuous for a later 24-bit rounding), then RNE to fp32 with
    // flush-to-zero on both input and output. Bit 32 marks a special-case operand pair.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        bit          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        real         r;
        logic [63:0] bits;
        logic [23:0] frac;
        bit          guard, sticky;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) return {1'b1, 32'h7FC0_0001};
        if ((a_inf && b_inf) || (a_zero && b_zero)) return {1'b1, 32'h7FC0_0001};
        if (a_inf || b_zero) return {1'b1, s, 8'hFF, 23'd0};
        if (a_zero || b_inf) return {1'b1, s, 31'd0};
        r      = real'(int'({1'b1, a[22:0]})) / real'(int'({1'b1, b[22:0]}));
        bits   = $realtobits(r);
        e      = int'(bits[62:52]) - 1023 + ea - eb + 127;
        frac   = {1'b0, bits[51:29]};
        guard  = bits[28];
        sticky = |bits[27:0];
        if (guard && (sticky || frac[0])) begin
            frac = frac + 24'd1;
            if (frac[23]) e++;
        end
        if (e >= 255) return {1'b1 & 1'b0, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, 8'(e), frac[22:0]};
    endfunction

    // Runs one operation from IDLE through the output transfer; caller is #1 after a posedge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input string tag);
        int lat;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, out_result, exp_res);
`ifdef FP32_DIV_FLAGS_EN
        last_flags = out_flags;
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drain"}, 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        logic [31:0] held;
        logic [32:0] m;
        logic [31:0] ra, rb;
        int          bad, pulses, lat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, NORMAL_LAT, "one_third");
        run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, NORMAL_LAT, "six_by_two");
`ifdef FP32_DIV_FLAGS_EN
        check("six_by_two_inexact", 32'(last_flags[0]), 32'd0);
`endif
        run_op(32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000, 1, "one_by_negzero");
        run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0001, 1, "zero_by_zero");
        run_op(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0001, 1, "inf_by_inf");
        run_op(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, NORMAL_LAT, "overflow");
        run_op(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, NORMAL_LAT, "underflow");
        run_op(32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 1, "denorm_flush");

        // Backpressure with a concurrent in_valid that must be ignored
        in_a     = 32'h3F80_0000;
        in_b     = 32'h4040_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'(NORMAL_LAT));
        held = out_result;
        check("bp_result", held, 32'h3EAA_AAAB);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_a     = 32'h40C0_0000;
            in_b     = 32'h4000_0000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            if (out_result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        check("bp_hold_cycles_bad", 32'(bad), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_drain", 32'({in_ready, out_valid}), 32'b10);
        pulses = 0;
        for (int i = 0; i < NORMAL_LAT + 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("bp_ignored_input", 32'(pulses), 32'd0);

        // Reset in the middle of DIVIDE
        in_a     = 32'h40C0_0000;
        in_b     = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_state", 32'({in_ready, out_valid}), 32'b10);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < NORMAL_LAT + 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("abort_no_stale", 32'(pulses), 32'd0);
        run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, NORMAL_LAT, "after_abort");
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("after_abort_single_pulse", 32'(pulses), 32'd0);

        // Randomized operands against the reference model
        for (int i = 0; i < 60; i++) begin
            ra = $urandom();
            rb = $urandom();
            if (i % 2 == 1) rb[30:23] = ra[30:23] ^ 8'($urandom_range(0, 7));
            m = ref_div(ra, rb);
            run_op(ra, rb, m[31:0], m[32] ? 1 : NORMAL_LAT, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
